// File: rtl/count_seq_pkg.sv
// rtl/count_seq_pkg.sv - shared state type and reset bounds for the count sequencer
package count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int DEF_LO = 5;
    localparam int DEF_HI = 14;

endpackage

// File: rtl/count_seq_tick_gen.sv
// rtl/count_seq_tick_gen.sv - clock-enable divider producing one strobe every TICKS enabled cycles
module tick_gen #(
    parameter int TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            DW   = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [DW-1:0] LAST = DW'(TICKS - 1);

    logic [DW-1:0] r_div;
    logic          w_last;

    assign w_last = (r_div == LAST);

    // Divider advances only while enabled; clr dominates so an idle sequencer always restarts from zero.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= w_last ? '0 : r_div + DW'(1);
        end
    end

    // Strobe is combinational so the owner can register the count update on the same edge the divider wraps.
    assign tick = en && !clr && w_last;

endmodule

// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - run/pause/stop sequencer for the bounded display up-counter
module count_seq_ctrl #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int W       = 4,
    parameter int DEF_LO  = count_seq_pkg::DEF_LO,
    parameter int DEF_HI  = count_seq_pkg::DEF_HI
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_lo,
    input  logic [W-1:0] cfg_hi,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         tick,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic [1:0]   state
);

    import count_seq_pkg::*;

    localparam int           TICKS  = CLK_HZ / TICK_HZ;
    localparam logic [W-1:0] LO_RST = W'(DEF_LO);
    localparam logic [W-1:0] HI_RST = W'(DEF_HI);

    state_e       r_state;
    state_e       w_state_nxt;
    logic [W-1:0] r_lo;
    logic [W-1:0] r_hi;
    logic [W-1:0] r_count;
    logic         r_tick;
    logic         r_wrap;
    logic         r_cfg_err;
    logic         r_cfg_ready;

    logic         w_fire;
    logic         w_cfg_acc;
    logic         w_cfg_ok;
    logic         w_going_idle;
    logic         w_going_run;
    logic         w_at_hi;

    // Next-state decode: stop beats start beats pause; start in RUN is a no-op that also masks pause.
    always_comb begin
        w_state_nxt = r_state;
        if (stop) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_state_nxt = RUN;
                RUN:     if (!start && pause) w_state_nxt = PAUSE;
                PAUSE:   if (start || pause) w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_going_idle = (w_state_nxt == IDLE);
    assign w_going_run  = (w_state_nxt == RUN);
    assign w_cfg_acc    = cfg_valid && r_cfg_ready;
    assign w_cfg_ok     = w_cfg_acc && (cfg_lo <= cfg_hi);
    assign w_at_hi      = (r_count == r_hi);

    // Divider runs in every cycle that ends in RUN, so the start cycle itself counts toward the first tick.
    tick_gen #(
        .TICKS (TICKS)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (w_going_idle),
        .en    (w_going_run),
        .tick  (w_fire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bound registers: only a well-ordered request replaces them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lo <= LO_RST;
            r_hi <= HI_RST;
        end else if (w_cfg_ok) begin
            r_lo <= cfg_lo;
            r_hi <= cfg_hi;
        end
    end

    // Count and registered status pulses; a fresh load or any IDLE cycle pins the count to the lower bound.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= LO_RST;
            r_tick      <= 1'b0;
            r_wrap      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            r_tick      <= w_fire;
            r_wrap      <= w_fire && w_at_hi;
            r_cfg_err   <= w_cfg_acc && !w_cfg_ok;
            r_cfg_ready <= w_going_idle;
            if (w_cfg_ok) begin
                r_count <= cfg_lo;
            end else if (w_going_idle) begin
                r_count <= r_lo;
            end else if (w_fire) begin
                r_count <= w_at_hi ? r_lo : r_count + W'(1);
            end
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;
    assign tick      = r_tick;
    assign count     = r_count;
    assign wrap      = r_wrap;
    assign state     = r_state;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb/tb_count_seq_ctrl.sv - scoreboard bench for count_seq_ctrl with directed and random stimulus
module tb_count_seq_ctrl;

    localparam int TICKS = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [3:0] cfg_lo = '0;
    logic [3:0] cfg_hi = '0;
    logic       cfg_ready;
    logic       cfg_err;
    logic       tick;
    logic [3:0] count;
    logic       wrap;
    logic [1:0] state;

    typedef struct packed {
        logic [3:0] cnt;
        logic [1:0] st;
        logic       rdy;
        logic       tck;
        logic       wrp;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // reference model: mode 0 idle, 1 run, 2 pause; phase = enabled cycles since last tick
    int m_mode = 0;
    int m_lo = 5;
    int m_hi = 14;
    int m_cnt = 5;
    int m_phase = 0;
    bit last_acc = 0;
    int n_tick = 0;
    int n_wrap = 0;

    count_seq_ctrl #(
        .CLK_HZ  (4),
        .TICK_HZ (1),
        .W       (4),
        .DEF_LO  (5),
        .DEF_HI  (14)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .cfg_valid (cfg_valid),
        .cfg_lo    (cfg_lo),
        .cfg_hi    (cfg_hi),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .count     (count),
        .wrap      (wrap),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    task automatic cyc(input int rs, input int st, input int sp, input int pa,
                       input int cv, input int lo, input int hi);
        exp_t e;
        bit   acc;
        @(negedge clk);
        reset     = (rs != 0);
        start     = (st != 0);
        stop      = (sp != 0);
        pause     = (pa != 0);
        cfg_valid = (cv != 0);
        cfg_lo    = 4'(lo);
        cfg_hi    = 4'(hi);
        e   = '0;
        acc = 0;
        if (rs != 0) begin
            m_mode = 0; m_lo = 5; m_hi = 14; m_cnt = 5; m_phase = 0;
        end else begin
            acc = (cv != 0) && (m_mode == 0);
            if (acc) begin
                if (lo <= hi) begin
                    m_lo = lo; m_hi = hi; m_cnt = lo;
                end else begin
                    e.err = 1'b1;
                end
            end
            if (sp != 0) m_mode = 0;
            else if (m_mode == 0) begin
                if (st != 0) m_mode = 1;
            end else if (m_mode == 1) begin
                if (st == 0 && pa != 0) m_mode = 2;
            end else begin
                if (st != 0 || pa != 0) m_mode = 1;
            end
            if (m_mode == 0) begin
                m_phase = 0;
                m_cnt   = m_lo;
            end else if (m_mode == 1) begin
                m_phase++;
                if (m_phase == TICKS) begin
                    m_phase = 0;
                    e.tck   = 1'b1;
                    if (m_cnt == m_hi) begin
                        e.wrp = 1'b1;
                        m_cnt = m_lo;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
        e.cnt = 4'(m_cnt);
        e.st  = 2'(m_mode);
        e.rdy = (m_mode == 0);
        last_acc = acc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_tick += int'(tick);
        n_wrap += int'(wrap);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    // monitor: every cycle the DUT presents outputs, compare against the oldest prediction
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {count, state, cfg_ready, tick, wrap, cfg_err};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL sb t=%0t: got cnt=%0d st=%0d rdy=%0b tick=%0b wrap=%0b err=%0b want cnt=%0d st=%0d rdy=%0b tick=%0b wrap=%0b err=%0b",
                             $time, a.cnt, a.st, a.rdy, a.tck, a.wrp, a.err,
                             e.cnt, e.st, e.rdy, e.tck, e.wrp, e.err);
                end
            end
        end
    end

    initial begin
        bit         pend;
        logic [3:0] plo;
        logic [3:0] phi;

        // 1: reset then idle
        cyc(1, 0, 0, 0, 0, 0, 0);
        run(5);
        chk("rst_count", int'(count), 5);
        chk("rst_state", int'(state), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_pulses", int'({tick, wrap, cfg_err}), 0);

        // 2: full lap 5..14 and wrap back
        n_tick = 0; n_wrap = 0;
        cyc(0, 1, 0, 0, 0, 0, 0);
        run(43);
        chk("lap_ticks", n_tick, 11);
        chk("lap_wraps", n_wrap, 1);
        chk("lap_count", int'(count), 6);

        // 3: pause two cycles after the tick to 8, hold, resume
        run(8);
        chk("tick_at8", int'({tick, count}), 16 + 8);
        run(2);
        cyc(0, 0, 0, 1, 0, 0, 0);
        run(10);
        chk("paused_count", int'(count), 8);
        chk("paused_state", int'(state), 2);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("resume_no_tick", int'(tick), 0);
        run(1);
        chk("resume_tick", int'({tick, count}), 16 + 9);

        // 4: degenerate bounds, then a rejected load
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 3, 3);
        chk("load33_count", int'(count), 3);
        n_wrap = 0;
        cyc(0, 1, 0, 0, 0, 0, 0);
        run(11);
        chk("lohi_wraps", n_wrap, 3);
        chk("lohi_count", int'(count), 3);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 9, 2);
        chk("bad_cfg_err", int'(cfg_err), 1);
        run(1);
        chk("bad_cfg_err_pulse", int'(cfg_err), 0);
        chk("bad_cfg_count", int'(count), 3);
        cyc(0, 0, 0, 0, 1, 5, 14);

        // 5: start+stop together, reset mid-run
        cyc(0, 1, 1, 0, 0, 0, 0);
        chk("startstop_state", int'(state), 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        run(23);
        chk("run_count11", int'(count), 11);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("midrun_rst", int'({state, count}), 5);

        // 6: config held during RUN, accepted after stop
        cyc(0, 1, 0, 0, 0, 0, 0);
        run(2);
        repeat (6) cyc(0, 0, 0, 0, 1, 2, 7);
        chk("run_cfg_ready", int'(cfg_ready), 0);
        chk("run_cfg_count", int'(count), 7);
        cyc(0, 0, 1, 0, 1, 2, 7);
        chk("stop_idle", int'({state, cfg_ready, count}), 16 + 5);
        cyc(0, 0, 0, 0, 1, 2, 7);
        chk("held_cfg_accept", int'(count), 2);
        run(2);

        // random traffic against the model
        pend = 0; plo = '0; phi = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend && $urandom_range(0, 19) == 0) begin
                pend = 1;
                plo  = 4'($urandom_range(0, 15));
                phi  = 4'($urandom_range(0, 15));
            end
            cyc(($urandom_range(0, 299) == 0) ? 1 : 0,
                ($urandom_range(0, 7) == 0) ? 1 : 0,
                ($urandom_range(0, 15) == 0) ? 1 : 0,
                ($urandom_range(0, 9) == 0) ? 1 : 0,
                int'(pend), int'(plo), int'(phi));
            if (last_acc) pend = 0;
        end

        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
